// File: rtl/control_multicycle_pkg.sv
// Shared control definitions for the multicycle RISC-V style controller:
// opcode constants, FSM state encoding, datapath selector encodings and
// the instruction classes produced by the opcode classifier.
package control_multicycle_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LOAD      = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC     = 7'b001_0111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b001_1011;
    localparam logic [6:0] OPC_STORE     = 7'b010_0011;
    localparam logic [6:0] OPC_OP        = 7'b011_0011;
    localparam logic [6:0] OPC_LUI       = 7'b011_0111;
    localparam logic [6:0] OPC_OP_32     = 7'b011_1011;
    localparam logic [6:0] OPC_BRANCH    = 7'b110_0011;
    localparam logic [6:0] OPC_JALR      = 7'b110_0111;
    localparam logic [6:0] OPC_JAL       = 7'b110_1111;

    // FSM states; the encoding is visible on the debug state output
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // Register file write-data source
    typedef enum logic [2:0] {
        M2R_ALU  = 3'd0,
        M2R_MEM  = 3'd1,
        M2R_OP32 = 3'd2,
        M2R_LUI  = 3'd3,
        M2R_PC4  = 3'd4
    } mem_to_reg_t;

    // ALU operation class; OP means "decode funct3/funct7 in the ALU"
    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_SUB    = 2'd1,
        ALU_OP     = 2'd2,
        ALU_BRANCH = 2'd3
    } alu_op_t;

    // ALU operand A source; old_pc is the pc of the instruction in flight
    typedef enum logic [1:0] {
        SRC_A_RS1    = 2'd0,
        SRC_A_PC     = 2'd1,
        SRC_A_OLD_PC = 2'd2
    } src_a_t;

    // ALU operand B source
    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } src_b_t;

    // Instruction classes that steer the FSM
    typedef enum logic [3:0] {
        CLS_ILLEGAL   = 4'd0,
        CLS_ALU_REG   = 4'd1,
        CLS_ALU_IMM   = 4'd2,
        CLS_ALU_REG32 = 4'd3,
        CLS_ALU_IMM32 = 4'd4,
        CLS_LOAD      = 4'd5,
        CLS_STORE     = 4'd6,
        CLS_AUIPC     = 4'd7,
        CLS_LUI       = 4'd8,
        CLS_BRANCH    = 4'd9,
        CLS_JAL       = 4'd10,
        CLS_JALR      = 4'd11
    } inst_class_t;

    // True for the 32-bit word forms that only exist on RV64
    function automatic logic is_word_form(inst_class_t cls);
        return (cls == CLS_ALU_REG32) || (cls == CLS_ALU_IMM32);
    endfunction

    // True for classes that finish in EXECUTE (control transfers)
    function automatic logic is_jump_class(inst_class_t cls);
        return (cls == CLS_BRANCH) || (cls == CLS_JAL) || (cls == CLS_JALR);
    endfunction

endpackage

// File: rtl/control_opcode_class.sv
// Combinational opcode classifier: maps a 7-bit major opcode to an
// instruction class and a legal flag. The word forms (OP_32, OP_IMM_32)
// are only legal on a 64-bit machine.
module control_opcode_class
    import control_multicycle_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [6:0]  opcode,
    output inst_class_t inst_class,
    output logic        legal
);

    localparam logic HAS_WORD_OPS = (XLEN == 64);

    // Opcode to class lookup; anything unlisted is illegal
    always_comb begin
        inst_class = CLS_ILLEGAL;
        case (opcode)
            OPC_LOAD:      inst_class = CLS_LOAD;
            OPC_OP_IMM:    inst_class = CLS_ALU_IMM;
            OPC_AUIPC:     inst_class = CLS_AUIPC;
            OPC_OP_IMM_32: inst_class = HAS_WORD_OPS ? CLS_ALU_IMM32 : CLS_ILLEGAL;
            OPC_STORE:     inst_class = CLS_STORE;
            OPC_OP:        inst_class = CLS_ALU_REG;
            OPC_LUI:       inst_class = CLS_LUI;
            OPC_OP_32:     inst_class = HAS_WORD_OPS ? CLS_ALU_REG32 : CLS_ILLEGAL;
            OPC_BRANCH:    inst_class = CLS_BRANCH;
            OPC_JALR:      inst_class = CLS_JALR;
            OPC_JAL:       inst_class = CLS_JAL;
            default:       inst_class = CLS_ILLEGAL;
        endcase
    end

    assign legal = (inst_class != CLS_ILLEGAL);

endmodule

// File: rtl/control_multicycle.sv
// Multicycle controller FSM: FETCH -> DECODE -> EXECUTE -> [MEMORY] ->
// [WRITEBACK], with a sticky FAULT state for illegal opcodes and memory
// timeouts. Control outputs are decoded from the state register and the
// opcode latched in DECODE; the only inputs that feed outputs directly are
// the memory handshake (to strobe the cycle it completes) and the branch
// comparison in EXECUTE.
module control_multicycle
    import control_multicycle_pkg::*;
#(
    parameter int          XLEN        = 64,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] inst_opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       inst_mem_read_en,
    output logic       ir_write_en,
    output logic       pc_write_en,
    output logic       data_mem_read_en,
    output logic       data_mem_write_en,
    output logic       regfile_write_en,
    output logic [2:0] mem_to_reg_sel,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a_sel,
    output logic [1:0] alu_src_b_sel,
    output logic       inst_retired,
    output logic       fault,
    output logic [2:0] state
);

    // Wide enough to count up to MEM_TIMEOUT-1; one bit when disabled
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            state_reg;
    logic [6:0]        opcode_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    // Low from reset until the first clock edge after reset releases, so no
    // fetch is requested while reset is held.
    logic              run_reg;

    logic [6:0]        class_opcode;
    inst_class_t       inst_class;
    logic              legal;
    logic              timeout_hit;

    // In DECODE classify the incoming IR opcode (it is being latched this
    // cycle); afterwards classify the latched copy.
    assign class_opcode = (state_reg == ST_DECODE) ? inst_opcode : opcode_reg;

    control_opcode_class #(
        .XLEN (XLEN)
    ) u_opcode_class (
        .opcode     (class_opcode),
        .inst_class (inst_class),
        .legal      (legal)
    );

    // Fires on the last tolerated cycle of a memory wait
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                         (32'(wait_cnt_reg) == (MEM_TIMEOUT - 1));

    // State, opcode latch and wait counter; the counter restarts at zero on
    // every state change and only counts consecutive not-ready cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_FETCH;
            opcode_reg   <= '0;
            wait_cnt_reg <= '0;
            run_reg      <= 1'b0;
        end else begin
            run_reg      <= 1'b1;
            wait_cnt_reg <= '0;
            case (state_reg)
                ST_FETCH: begin
                    if (run_reg) begin
                        if (mem_ready) begin
                            state_reg <= ST_DECODE;
                        end else if (timeout_hit) begin
                            state_reg <= ST_FAULT;
                        end else if (MEM_TIMEOUT != 0) begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_DECODE: begin
                    opcode_reg <= inst_opcode;
                    state_reg  <= legal ? ST_EXECUTE : ST_FAULT;
                end
                ST_EXECUTE: begin
                    if ((inst_class == CLS_LOAD) || (inst_class == CLS_STORE)) begin
                        state_reg <= ST_MEMORY;
                    end else if (is_jump_class(inst_class)) begin
                        state_reg <= ST_FETCH;
                    end else begin
                        state_reg <= ST_WRITEBACK;
                    end
                end
                ST_MEMORY: begin
                    if (mem_ready) begin
                        state_reg <= (inst_class == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
                    end else if (timeout_hit) begin
                        state_reg <= ST_FAULT;
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_WRITEBACK: state_reg <= ST_FETCH;
                ST_FAULT:     state_reg <= ST_FAULT;
                default:      state_reg <= ST_FAULT;
            endcase
        end
    end

    // Output decode from state and instruction class; everything defaults to
    // idle so FAULT and the post-reset idle cycle drive no enables.
    always_comb begin
        inst_mem_read_en  = 1'b0;
        ir_write_en       = 1'b0;
        pc_write_en       = 1'b0;
        data_mem_read_en  = 1'b0;
        data_mem_write_en = 1'b0;
        regfile_write_en  = 1'b0;
        mem_to_reg_sel    = M2R_ALU;
        alu_op            = ALU_ADD;
        alu_src_a_sel     = SRC_A_RS1;
        alu_src_b_sel     = SRC_B_RS2;
        inst_retired      = 1'b0;
        fault             = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                // pc <= pc + 4 and IR load happen on the cycle memory answers
                alu_src_a_sel = SRC_A_PC;
                alu_src_b_sel = SRC_B_FOUR;
                if (run_reg) begin
                    inst_mem_read_en = 1'b1;
                    ir_write_en      = mem_ready;
                    pc_write_en      = mem_ready;
                end
            end
            ST_DECODE: begin
                // Speculative branch/jump target old_pc + imm
                alu_src_a_sel = SRC_A_OLD_PC;
                alu_src_b_sel = SRC_B_IMM;
            end
            ST_EXECUTE: begin
                case (inst_class)
                    CLS_ALU_REG, CLS_ALU_REG32: begin
                        alu_op        = ALU_OP;
                        alu_src_b_sel = SRC_B_RS2;
                    end
                    CLS_ALU_IMM, CLS_ALU_IMM32: begin
                        alu_op        = ALU_OP;
                        alu_src_b_sel = SRC_B_IMM;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b_sel = SRC_B_IMM;
                    end
                    CLS_AUIPC: begin
                        alu_src_a_sel = SRC_A_OLD_PC;
                        alu_src_b_sel = SRC_B_IMM;
                    end
                    CLS_LUI: begin
                        alu_src_b_sel = SRC_B_IMM;
                    end
                    CLS_BRANCH: begin
                        alu_op       = ALU_BRANCH;
                        pc_write_en  = branch_taken;
                        inst_retired = 1'b1;
                    end
                    CLS_JAL: begin
                        alu_src_a_sel    = SRC_A_OLD_PC;
                        alu_src_b_sel    = SRC_B_IMM;
                        pc_write_en      = 1'b1;
                        regfile_write_en = 1'b1;
                        mem_to_reg_sel   = M2R_PC4;
                        inst_retired     = 1'b1;
                    end
                    CLS_JALR: begin
                        alu_src_b_sel    = SRC_B_IMM;
                        pc_write_en      = 1'b1;
                        regfile_write_en = 1'b1;
                        mem_to_reg_sel   = M2R_PC4;
                        inst_retired     = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEMORY: begin
                // Keep the address selection stable for the whole access
                alu_src_b_sel     = SRC_B_IMM;
                data_mem_read_en  = (inst_class == CLS_LOAD);
                data_mem_write_en = (inst_class == CLS_STORE);
                inst_retired      = (inst_class == CLS_STORE) && mem_ready;
            end
            ST_WRITEBACK: begin
                regfile_write_en = 1'b1;
                inst_retired     = 1'b1;
                if (inst_class == CLS_LOAD) begin
                    mem_to_reg_sel = M2R_MEM;
                end else if (is_word_form(inst_class)) begin
                    mem_to_reg_sel = M2R_OP32;
                end else if (inst_class == CLS_LUI) begin
                    mem_to_reg_sel = M2R_LUI;
                end else begin
                    mem_to_reg_sel = M2R_ALU;
                end
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_reg;

endmodule

// File: tb/tb_control_multicycle.sv
// Directed bench for control_multicycle. Three instances share stimulus:
// k=0 XLEN=64 no timeout, k=1 XLEN=32, k=2 XLEN=64 with MEM_TIMEOUT=4.
// Per cycle the status vector is
// {state[2:0], imem_rd, ir_we, pc_we, dmem_rd, dmem_we, rf_we, retired, fault}.
module tb_control_multicycle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] inst_opcode = 7'h00;
    logic       mem_ready = 1'b1;
    logic       branch_taken = 1'b0;

    logic       imr [3];
    logic       irw [3];
    logic       pcw [3];
    logic       dmr [3];
    logic       dmw [3];
    logic       rfw [3];
    logic [2:0] m2r [3];
    logic [1:0] aop [3];
    logic [1:0] sa  [3];
    logic [1:0] sb  [3];
    logic       ret [3];
    logic       flt [3];
    logic [2:0] st  [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        control_multicycle #(
            .XLEN        ((gi == 1) ? 32 : 64),
            .MEM_TIMEOUT ((gi == 2) ? 4 : 0)
        ) dut (
            .clock             (clock),
            .reset             (reset),
            .inst_opcode       (inst_opcode),
            .mem_ready         (mem_ready),
            .branch_taken      (branch_taken),
            .inst_mem_read_en  (imr[gi]),
            .ir_write_en       (irw[gi]),
            .pc_write_en       (pcw[gi]),
            .data_mem_read_en  (dmr[gi]),
            .data_mem_write_en (dmw[gi]),
            .regfile_write_en  (rfw[gi]),
            .mem_to_reg_sel    (m2r[gi]),
            .alu_op            (aop[gi]),
            .alu_src_a_sel     (sa[gi]),
            .alu_src_b_sel     (sb[gi]),
            .inst_retired      (ret[gi]),
            .fault             (flt[gi]),
            .state             (st[gi])
        );
    end

    // Hand-derived status vectors
    localparam logic [10:0] IDLE   = {3'd0, 8'b0000_0000};
    localparam logic [10:0] F_OK   = {3'd0, 8'b1110_0000};
    localparam logic [10:0] F_WAIT = {3'd0, 8'b1000_0000};
    localparam logic [10:0] DEC    = {3'd1, 8'b0000_0000};
    localparam logic [10:0] EXE    = {3'd2, 8'b0000_0000};
    localparam logic [10:0] WB     = {3'd4, 8'b0000_0110};
    localparam logic [10:0] FLT    = {3'd5, 8'b0000_0001};

    // ALU selector expectations {skip, alu_op, src_a, src_b}; m2r {skip, sel}
    localparam logic [6:0] NOS = 7'h40;
    localparam logic [3:0] NOM = 4'h8;

    function automatic logic [6:0] alu(logic [1:0] op, logic [1:0] a, logic [1:0] b);
        return {1'b0, op, a, b};
    endfunction

    function automatic logic [3:0] m2(logic [2:0] m);
        return {1'b0, m};
    endfunction

    function automatic logic [10:0] obs(int k);
        return {st[k], imr[k], irw[k], pcw[k], dmr[k], dmw[k], rfw[k], ret[k], flt[k]};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample one cycle at the falling edge, then advance past the next rise
    task automatic step(string tag, int k, logic [10:0] exp,
                        logic [6:0] sx = NOS, logic [3:0] mx = NOM);
        @(negedge clock);
        check({tag, ".st"}, 32'(obs(k)), 32'(exp));
        if (!sx[6]) check({tag, ".alu"}, 32'({aop[k], sa[k], sb[k]}), 32'(sx[5:0]));
        if (!mx[3]) check({tag, ".m2r"}, 32'(m2r[k]), 32'(mx[2:0]));
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic txn(string name);
        $display("txn %-10s cycles=%0d compared=%0d mismatched=%0d", name, cyc, n_cmp, n_bad);
        cyc = 0;
    endtask

    // Reset, check all instances idle, release at mid-cycle; returns at the
    // start of the first fetch cycle.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        branch_taken = 1'b0;
        @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 3; k++) check("rst", 32'(obs(k)), 32'(IDLE));
        reset = 1'b0;
        #1;
        check("rst.idle", 32'(obs(0)), 32'(IDLE));
        @(posedge clock);
        #1;
        cyc = 0;
    endtask

    initial begin
        do_reset();

        // ADD
        inst_opcode = 7'h33;
        step("add.f", 0, F_OK, alu(2'd0, 2'd1, 2'd2));
        step("add.d", 0, DEC,  alu(2'd0, 2'd2, 2'd1));
        step("add.e", 0, EXE,  alu(2'd2, 2'd0, 2'd0));
        step("add.wb", 0, WB, NOS, m2(3'd0));
        txn("ADD");

        // ADDI
        inst_opcode = 7'h13;
        step("addi.f", 0, F_OK);
        step("addi.d", 0, DEC);
        step("addi.e", 0, EXE, alu(2'd2, 2'd0, 2'd1));
        step("addi.wb", 0, WB, NOS, m2(3'd0));
        txn("ADDI");

        // LOAD with two wait cycles in MEMORY
        inst_opcode = 7'h03;
        step("ld.f", 0, F_OK);
        step("ld.d", 0, DEC);
        mem_ready = 1'b0;
        step("ld.e", 0, EXE, alu(2'd0, 2'd0, 2'd1));
        step("ld.m1", 0, {3'd3, 8'b0001_0000});
        step("ld.m2", 0, {3'd3, 8'b0001_0000});
        mem_ready = 1'b1;
        step("ld.m3", 0, {3'd3, 8'b0001_0000});
        step("ld.wb", 0, WB, NOS, m2(3'd1));
        txn("LOAD");

        // STORE, zero wait
        inst_opcode = 7'h23;
        step("st.f", 0, F_OK);
        step("st.d", 0, DEC);
        step("st.e", 0, EXE, alu(2'd0, 2'd0, 2'd1));
        step("st.m", 0, {3'd3, 8'b0000_1010});
        txn("STORE");

        // BRANCH not taken, then taken
        inst_opcode = 7'h63;
        step("bnt.f", 0, F_OK);
        step("bnt.d", 0, DEC);
        branch_taken = 1'b0;
        step("bnt.e", 0, {3'd2, 8'b0000_0010}, alu(2'd3, 2'd0, 2'd0));
        txn("BRANCH_NT");
        step("bt.f", 0, F_OK);
        step("bt.d", 0, DEC);
        branch_taken = 1'b1;
        step("bt.e", 0, {3'd2, 8'b0010_0010}, alu(2'd3, 2'd0, 2'd0));
        branch_taken = 1'b0;
        txn("BRANCH_T");

        // JAL and JALR
        inst_opcode = 7'h6F;
        step("jal.f", 0, F_OK);
        step("jal.d", 0, DEC);
        step("jal.e", 0, {3'd2, 8'b0010_0110}, alu(2'd0, 2'd2, 2'd1), m2(3'd4));
        txn("JAL");
        inst_opcode = 7'h67;
        step("jalr.f", 0, F_OK);
        step("jalr.d", 0, DEC);
        step("jalr.e", 0, {3'd2, 8'b0010_0110}, alu(2'd0, 2'd0, 2'd1), m2(3'd4));
        txn("JALR");

        // LUI, AUIPC
        inst_opcode = 7'h37;
        step("lui.f", 0, F_OK);
        step("lui.d", 0, DEC);
        step("lui.e", 0, EXE);
        step("lui.wb", 0, WB, NOS, m2(3'd3));
        txn("LUI");
        inst_opcode = 7'h17;
        step("auipc.f", 0, F_OK);
        step("auipc.d", 0, DEC);
        step("auipc.e", 0, EXE, alu(2'd0, 2'd2, 2'd1));
        step("auipc.wb", 0, WB, NOS, m2(3'd0));
        txn("AUIPC");

        // Word forms on RV64
        inst_opcode = 7'h3B;
        step("op32.f", 0, F_OK);
        step("op32.d", 0, DEC);
        step("op32.e", 0, EXE, alu(2'd2, 2'd0, 2'd0));
        step("op32.wb", 0, WB, NOS, m2(3'd2));
        txn("OP_32");
        inst_opcode = 7'h1B;
        step("opi32.f", 0, F_OK);
        step("opi32.d", 0, DEC);
        step("opi32.e", 0, EXE, alu(2'd2, 2'd0, 2'd1));
        step("opi32.wb", 0, WB, NOS, m2(3'd2));
        txn("OP_IMM_32");

        // Fetch wait of one cycle; mem_ready low in DECODE/EXECUTE is ignored
        inst_opcode = 7'h33;
        mem_ready = 1'b0;
        step("fw.f1", 0, F_WAIT);
        mem_ready = 1'b1;
        step("fw.f2", 0, F_OK);
        mem_ready = 1'b0;
        step("fw.d", 0, DEC);
        step("fw.e", 0, EXE);
        mem_ready = 1'b1;
        step("fw.wb", 0, WB, NOS, m2(3'd0));
        txn("ADD_WAIT");

        // Illegal opcode on RV64
        inst_opcode = 7'h7F;
        step("ill.f", 0, F_OK);
        step("ill.d", 0, DEC);
        for (int i = 0; i < 3; i++) step("ill.flt", 0, FLT);
        txn("ILLEGAL");

        // OP_32 on RV32 faults and stays faulted
        do_reset();
        inst_opcode = 7'h3B;
        step("x32.f", 1, F_OK);
        step("x32.d", 1, DEC);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step("x32.flt", 1, FLT);
        end
        txn("OP_32_RV32");
        do_reset();

        // Fetch timeout after four wait cycles; k=0 has no timeout
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("to.f", 2, F_WAIT);
        @(negedge clock);
        check("to.flt", 32'(obs(2)), 32'(FLT));
        check("to.none", 32'(obs(0)), 32'(F_WAIT));
        @(posedge clock);
        #1;
        cyc = cyc + 1;
        txn("TIMEOUT");

        // Reset during a STORE memory wait
        do_reset();
        inst_opcode = 7'h23;
        step("rs.f", 0, F_OK);
        step("rs.d", 0, DEC);
        mem_ready = 1'b0;
        step("rs.e", 0, EXE);
        @(negedge clock);
        check("rs.m", 32'(obs(0)), 32'({3'd3, 8'b0000_1000}));
        #1;
        reset = 1'b1;
        #1;
        check("rs.async", 32'(obs(0)), 32'(IDLE));
        @(posedge clock);
        #1;
        check("rs.hold", 32'(obs(0)), 32'(IDLE));
        txn("STORE_RST");
        do_reset();
        inst_opcode = 7'h33;
        step("post.f", 0, F_OK);
        txn("RECOVER");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
